// File: rtl/ps2k_tx.sv
// PS/2 keyboard-device transmitter: queues {ext, make, code} key events and
// serialises each as E0/F0/code device-to-host frames on an open-collector ck/d pair.
module ps2k_tx #(
  parameter int CLKDIV = 2000,
  parameter int DEPTH  = 8,
  parameter int GAP    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strb,
  input  logic       make,
  input  logic       ext,
  input  logic [7:0] code,
  output logic       full,
  output logic       busy,
  output logic       ovf,
  output logic       ps2Ck,
  output logic       ps2D
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(CLKDIV * GAP);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKDIV - 1);
  localparam logic [HW-1:0] GAP_LAST  = HW'(CLKDIV * GAP - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        state_r, stateNext_s;
  logic [HW-1:0] halfCnt_r, halfCntNext_s;
  logic [3:0]    bitIdx_r, bitIdxNext_s;
  logic [7:0]    curByte_r, byteNext_s;
  logic [7:0]    code_r, codeNext_s;
  logic          pendF0_r, pendF0Next_s;
  logic          pendCode_r, pendCodeNext_s;
  logic          dNext_s;

  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] wrPtr_r, rdPtr_r;
  logic [AW:0]   count_r, countNext_s;
  logic [9:0]    head_s;
  logic          push_s, pop_s, ovfNext_s;
  logic          full_r, busy_r, ovf_r, ck_r, d_r;

  function automatic logic oddParity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic frameBit(input logic [7:0] b, input logic [3:0] idx);
    logic [10:0] f;
    f = {1'b1, oddParity(b), b, 1'b0};
    return (idx > 4'd10) ? 1'b1 : f[idx];
  endfunction

  assign head_s = mem_r[rdPtr_r];

  // FIFO accounting: a pop in the same cycle frees the slot a full FIFO needs
  always_comb begin
    push_s      = strb && ((count_r != FULL_CNT) || pop_s);
    ovfNext_s   = strb && (count_r == FULL_CNT) && !pop_s;
    countNext_s = count_r;
    case ({push_s, pop_s})
      2'b10:   countNext_s = count_r + (AW + 1)'(1);
      2'b01:   countNext_s = count_r - (AW + 1)'(1);
      default: countNext_s = count_r;
    endcase
  end

  // Frame FSM; byte selection happens on the transition into HI so no cycle is lost
  always_comb begin
    stateNext_s    = state_r;
    halfCntNext_s  = halfCnt_r + HW'(1);
    bitIdxNext_s   = bitIdx_r;
    byteNext_s     = curByte_r;
    codeNext_s     = code_r;
    pendF0Next_s   = pendF0_r;
    pendCodeNext_s = pendCode_r;
    pop_s          = 1'b0;
    case (state_r)
      S_IDLE: begin
        halfCntNext_s = {HW{1'b0}};
        if (count_r != {(AW + 1){1'b0}}) begin
          pop_s        = 1'b1;
          stateNext_s  = S_HI;
          bitIdxNext_s = 4'd0;
          codeNext_s   = head_s[7:0];
          if (head_s[9]) begin
            byteNext_s     = 8'hE0;
            pendF0Next_s   = ~head_s[8];
            pendCodeNext_s = 1'b1;
          end else if (!head_s[8]) begin
            byteNext_s     = 8'hF0;
            pendF0Next_s   = 1'b0;
            pendCodeNext_s = 1'b1;
          end else begin
            byteNext_s     = head_s[7:0];
            pendF0Next_s   = 1'b0;
            pendCodeNext_s = 1'b0;
          end
        end else begin
          stateNext_s = S_IDLE;
        end
      end
      S_HI: begin
        if (halfCnt_r == HALF_LAST) begin
          stateNext_s   = S_LO;
          halfCntNext_s = {HW{1'b0}};
        end else begin
          stateNext_s = S_HI;
        end
      end
      S_LO: begin
        if (halfCnt_r == HALF_LAST) begin
          halfCntNext_s = {HW{1'b0}};
          if (bitIdx_r < 4'd10) begin
            bitIdxNext_s = bitIdx_r + 4'd1;
            stateNext_s  = S_HI;
          end else begin
            stateNext_s = S_GAP;
          end
        end else begin
          stateNext_s = S_LO;
        end
      end
      S_GAP: begin
        if (halfCnt_r == GAP_LAST) begin
          halfCntNext_s = {HW{1'b0}};
          if (pendF0_r || pendCode_r) begin
            stateNext_s  = S_HI;
            bitIdxNext_s = 4'd0;
            if (pendF0_r) begin
              byteNext_s   = 8'hF0;
              pendF0Next_s = 1'b0;
            end else begin
              byteNext_s     = code_r;
              pendCodeNext_s = 1'b0;
            end
          end else begin
            stateNext_s = S_IDLE;
          end
        end else begin
          stateNext_s = S_GAP;
        end
      end
      default: begin
        stateNext_s   = S_IDLE;
        halfCntNext_s = {HW{1'b0}};
      end
    endcase
    case (stateNext_s)
      S_HI:    dNext_s = frameBit(byteNext_s, bitIdxNext_s);
      S_LO:    dNext_s = d_r;
      default: dNext_s = 1'b1;
    endcase
  end

  // FIFO storage; pointers alone define contents, so no reset is needed here
  always_ff @(posedge clock) begin
    if (push_s) mem_r[wrPtr_r] <= {ext, make, code};
  end

  // State, counters, pointers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_IDLE;
      halfCnt_r  <= {HW{1'b0}};
      bitIdx_r   <= 4'd0;
      curByte_r  <= 8'h00;
      code_r     <= 8'h00;
      pendF0_r   <= 1'b0;
      pendCode_r <= 1'b0;
      wrPtr_r    <= {AW{1'b0}};
      rdPtr_r    <= {AW{1'b0}};
      count_r    <= {(AW + 1){1'b0}};
      full_r     <= 1'b0;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
      ck_r       <= 1'b1;
      d_r        <= 1'b1;
    end else begin
      state_r    <= stateNext_s;
      halfCnt_r  <= halfCntNext_s;
      bitIdx_r   <= bitIdxNext_s;
      curByte_r  <= byteNext_s;
      code_r     <= codeNext_s;
      pendF0_r   <= pendF0Next_s;
      pendCode_r <= pendCodeNext_s;
      if (push_s) wrPtr_r <= wrPtr_r + AW'(1);
      if (pop_s)  rdPtr_r <= rdPtr_r + AW'(1);
      count_r    <= countNext_s;
      full_r     <= (countNext_s == FULL_CNT);
      busy_r     <= (countNext_s != {(AW + 1){1'b0}}) || (stateNext_s != S_IDLE);
      ovf_r      <= ovfNext_s;
      ck_r       <= (stateNext_s != S_LO);
      d_r        <= dNext_s;
    end
  end

  assign full  = full_r;
  assign busy  = busy_r;
  assign ovf   = ovf_r;
  assign ps2Ck = ck_r;
  assign ps2D  = d_r;

endmodule

// File: tb/tb_ps2k_tx.sv
// Directed bench for ps2k_tx (CLKDIV=4, DEPTH=8, GAP=4); a line monitor decodes
// frames on ck falls and flags data changes while ck is low.
module tb_ps2k_tx;

  logic       clock = 1'b0;
  logic       reset, strb, make, ext;
  logic [7:0] code;
  logic       full, busy, ovf, ps2Ck, ps2D;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          bitCnt = 0;
  int          fallCnt = 0;
  int          dErr = 0;
  int          frameErr = 0;
  int          curFirst = 0;
  logic        prevCk = 1'b1;
  logic        prevD = 1'b1;
  logic [10:0] shiftReg = 11'h000;
  logic [10:0] rxFrames[$];
  int          frFirst[$];
  int          frLast[$];

  ps2k_tx #(.CLKDIV(4), .DEPTH(8), .GAP(4)) dut (
    .clock(clock), .reset(reset), .strb(strb), .make(make), .ext(ext), .code(code),
    .full(full), .busy(busy), .ovf(ovf), .ps2Ck(ps2Ck), .ps2D(ps2D)
  );

  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // host-side monitor: sample on ck falls, check frame shape and data stability
  initial forever begin
    @(negedge clock);
    if (reset !== 1'b0) begin
      bitCnt = 0;
    end else begin
      if (prevCk === 1'b0 && ps2Ck === 1'b0 && ps2D !== prevD) dErr++;
      if (prevCk === 1'b1 && ps2Ck === 1'b0) begin
        fallCnt++;
        if (bitCnt == 0) curFirst = cyc;
        shiftReg[bitCnt] = ps2D;
        bitCnt++;
        if (bitCnt == 11) begin
          rxFrames.push_back(shiftReg);
          frFirst.push_back(curFirst);
          frLast.push_back(cyc);
          if (shiftReg[0] !== 1'b0 || shiftReg[10] !== 1'b1 || (^shiftReg[9:1]) !== 1'b1) frameErr++;
          bitCnt = 0;
        end
      end
    end
    prevCk = ps2Ck;
    prevD  = ps2D;
  end

  task automatic sendEvent(input logic e, input logic m, input logic [7:0] c);
    strb = 1'b1; ext = e; make = m; code = c;
    @(negedge clock);
    strb = 1'b0;
  endtask

  task automatic waitIdle(input int limit, output int idleCyc);
    idleCyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (busy === 1'b0) begin
        idleCyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; strb = 1'b0; make = 1'b0; ext = 1'b0; code = 8'h00;
    repeat (3) @(negedge clock);
    checks++; if (ps2Ck !== 1'b1) begin errors++; $display("FAIL reset_ck got %b want 1", ps2Ck); end
    checks++; if (ps2D !== 1'b1) begin errors++; $display("FAIL reset_d got %b want 1", ps2D); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_frame();
    logic [10:0] expF;
    logic        bad;
    expF = 11'h438;
    sendEvent(1'b0, 1'b1, 8'h1C);
    checks++;
    if (ps2D !== 1'b1 || ps2Ck !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL t1_pop_cycle got ck=%b d=%b busy=%b want 1 1 1", ps2Ck, ps2D, busy);
    end
    @(negedge clock);
    for (int b = 0; b < 11; b++) begin
      bad = 1'b0;
      repeat (4) begin
        if (ps2Ck !== 1'b1 || ps2D !== expF[b]) bad = 1'b1;
        @(negedge clock);
      end
      checks++; if (bad) begin errors++; $display("FAIL t1_hi bit %0d ck=%b d=%b want ck=1 d=%b", b, ps2Ck, ps2D, expF[b]); end
      bad = 1'b0;
      repeat (4) begin
        if (ps2Ck !== 1'b0 || ps2D !== expF[b]) bad = 1'b1;
        @(negedge clock);
      end
      checks++; if (bad) begin errors++; $display("FAIL t1_lo bit %0d ck=%b d=%b want ck=0 d=%b", b, ps2Ck, ps2D, expF[b]); end
    end
    bad = 1'b0;
    repeat (16) begin
      if (ps2Ck !== 1'b1 || ps2D !== 1'b1 || busy !== 1'b1) bad = 1'b1;
      @(negedge clock);
    end
    checks++; if (bad) begin errors++; $display("FAIL t1_gap ck=%b d=%b busy=%b want 1 1 1", ps2Ck, ps2D, busy); end
    checks++;
    if (busy !== 1'b0 || ps2Ck !== 1'b1 || ps2D !== 1'b1) begin
      errors++; $display("FAIL t1_idle busy=%b ck=%b d=%b want 0 1 1", busy, ps2Ck, ps2D);
    end
    checks++;
    if (rxFrames.size() != 1 || rxFrames[0] !== 11'h438) begin
      errors++; $display("FAIL t1_frame count=%0d want 1 value=%h want 438", rxFrames.size(), (rxFrames.size() > 0) ? rxFrames[0] : 11'h0);
    end
  endtask

  task automatic test_ext_break();
    int base, idleCyc;
    base = rxFrames.size();
    sendEvent(1'b1, 1'b0, 8'h74);
    waitIdle(600, idleCyc);
    checks++; if (idleCyc < 0) begin errors++; $display("FAIL t2_timeout busy still %b want 0", busy); end
    checks++; if (rxFrames.size() != base + 3) begin errors++; $display("FAIL t2_count got %0d want %0d", rxFrames.size() - base, 3); end
    if (rxFrames.size() == base + 3) begin
      checks++; if (rxFrames[base] !== 11'h5C0) begin errors++; $display("FAIL t2_e0 got %h want 5c0", rxFrames[base]); end
      checks++; if (rxFrames[base+1] !== 11'h7E0) begin errors++; $display("FAIL t2_f0 got %h want 7e0", rxFrames[base+1]); end
      checks++; if (rxFrames[base+2] !== 11'h6E8) begin errors++; $display("FAIL t2_74 got %h want 6e8", rxFrames[base+2]); end
      checks++; if (frFirst[base+1] - frLast[base] != 24) begin errors++; $display("FAIL t2_gap1 got %0d want 24", frFirst[base+1] - frLast[base]); end
      checks++; if (frFirst[base+2] - frLast[base+1] != 24) begin errors++; $display("FAIL t2_gap2 got %0d want 24", frFirst[base+2] - frLast[base+1]); end
      checks++; if (idleCyc - frLast[base+2] != 20) begin errors++; $display("FAIL t2_busy_drop got %0d want 20", idleCyc - frLast[base+2]); end
    end
  endtask

  task automatic test_overflow();
    int base, idleCyc;
    logic [10:0] expT[9];
    expT = '{11'h402, 11'h404, 11'h606, 11'h408, 11'h60A, 11'h60C, 11'h40E, 11'h410, 11'h612};
    base = rxFrames.size();
    for (int k = 0; k < 10; k++) begin
      strb = 1'b1; ext = 1'b0; make = 1'b1; code = 8'(k + 1);
      if (k == 8) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL t3_full_early got %b want 0", full); end end
      if (k == 9) begin checks++; if (full !== 1'b1) begin errors++; $display("FAIL t3_full got %b want 1", full); end end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL t3_ovf_quiet k=%0d got %b want 0", k, ovf); end
      @(negedge clock);
    end
    strb = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL t3_ovf_pulse got %b want 1", ovf); end
    @(negedge clock);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL t3_ovf_end got %b want 0", ovf); end
    waitIdle(3000, idleCyc);
    checks++; if (idleCyc < 0) begin errors++; $display("FAIL t3_timeout busy still %b want 0", busy); end
    checks++; if (rxFrames.size() != base + 9) begin errors++; $display("FAIL t3_count got %0d want 9", rxFrames.size() - base); end
    if (rxFrames.size() == base + 9) begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (rxFrames[base+k] !== expT[k]) begin errors++; $display("FAIL t3_frame %0d got %h want %h", k, rxFrames[base+k], expT[k]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    bit hit;
    logic bad;
    for (int k = 0; k < 4; k++) begin
      strb = 1'b1; ext = 1'b0; make = 1'b1; code = 8'(8'h15 + k);
      @(negedge clock);
    end
    strb = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bitCnt == 5) begin hit = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (!hit) begin errors++; $display("FAIL t4_reach_bit5 bitCnt=%0d want 5", bitCnt); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (ps2Ck !== 1'b1 || ps2D !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL t4_after_reset ck=%b d=%b busy=%b full=%b want 1 1 0 0", ps2Ck, ps2D, busy, full);
    end
    reset = 1'b0;
    f0 = fallCnt;
    bad = 1'b0;
    repeat (150) begin
      @(negedge clock);
      if (ps2Ck !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad || fallCnt != f0) begin errors++; $display("FAIL t4_quiet falls=%0d want 0 ck=%b busy=%b", fallCnt - f0, ps2Ck, busy); end
  endtask

  task automatic test_push_pop_same_cycle();
    int base, c0, idleCyc;
    base = rxFrames.size();
    c0 = cyc;
    sendEvent(1'b0, 1'b1, 8'h29);
    while (cyc < c0 + 10) @(negedge clock);
    sendEvent(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 200 && cyc < c0 + 106; i++) @(negedge clock);
    sendEvent(1'b0, 1'b1, 8'h66);
    checks++;
    if (ovf !== 1'b0 || full !== 1'b0 || busy !== 1'b1 || ps2D !== 1'b0) begin
      errors++; $display("FAIL t5_same_cycle ovf=%b full=%b busy=%b d=%b want 0 0 1 0", ovf, full, busy, ps2D);
    end
    waitIdle(1000, idleCyc);
    checks++; if (idleCyc < 0) begin errors++; $display("FAIL t5_timeout busy still %b want 0", busy); end
    checks++; if (rxFrames.size() != base + 3) begin errors++; $display("FAIL t5_count got %0d want 3", rxFrames.size() - base); end
    if (rxFrames.size() == base + 3) begin
      checks++; if (rxFrames[base] !== 11'h452) begin errors++; $display("FAIL t5_a got %h want 452", rxFrames[base]); end
      checks++; if (rxFrames[base+1] !== 11'h6B4) begin errors++; $display("FAIL t5_b got %h want 6b4", rxFrames[base+1]); end
      checks++; if (rxFrames[base+2] !== 11'h6CC) begin errors++; $display("FAIL t5_c got %h want 6cc", rxFrames[base+2]); end
    end
  endtask

  task automatic test_protocol();
    checks++; if (dErr != 0) begin errors++; $display("FAIL t6_d_stable changes_while_ck_low=%0d want 0", dErr); end
    checks++; if (frameErr != 0) begin errors++; $display("FAIL t6_frame_shape bad_frames=%0d want 0", frameErr); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ext_break();
    test_overflow();
    test_reset_midframe();
    test_push_pop_same_cycle();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
